// File: rtl/disp_arbiter_pkg.sv
// Shared types and defaults for the display arbiter: FSM state encoding,
// owner encoding and the default MMIO addresses.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL     = 2'd0,
    ST_DEBUG      = 2'd1,
    ST_REPLAY_LED = 2'd2,
    ST_REPLAY_SEG = 2'd3
  } disp_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam logic [31:0] DEF_LED_ADDR  = 32'hFFFF_FC60;
  localparam logic [31:0] DEF_SEG_ADDR  = 32'hFFFF_FC64;
  localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FC68;

  localparam int DEF_MAX_WAIT = 8;
  localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/disp_arbiter_sync_2ff.sv
// Two-flop synchroniser for the asynchronous debug mode switch.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Display arbiter between CPU MMIO stores and a debug monitor writer.
// Build option DISP_REPLAY_EN: shadow CPU display writes during debug and replay them on exit.
//
// state         | meaning
// ST_NORMAL     | CPU owns display, debug writes arbitrated with anti-starvation
// ST_DEBUG      | debug owns display, CPU display writes shadowed (or dropped)
// ST_REPLAY_LED | replay shadowed LED value if dirty
// ST_REPLAY_SEG | replay shadowed segment value if dirty
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter logic [31:0] LED_ADDR  = DEF_LED_ADDR,
  parameter logic [31:0] SEG_ADDR  = DEF_SEG_ADDR,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          MAX_WAIT  = DEF_MAX_WAIT,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dbg_mode,
  input  logic        dbg_valid,
  input  logic        dbg_sel,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic        led_ctrl,
  output logic        seg_ctrl,
  output logic [31:0] write_data,
  output logic        base,
  output logic        owner
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  disp_state_e      state;
  logic             mode_s;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_is_led;
  logic             cpu_disp_req;
  logic             cpu_base_wr;
  logic             dbg_force;

`ifdef DISP_REPLAY_EN
  logic [31:0] shadow_led;
  logic [31:0] shadow_seg;
  logic        dirty_led;
  logic        dirty_seg;
`endif

  sync_2ff u_mode_sync (
    .clk (clk),
    .rst (rst),
    .d   (dbg_mode),
    .q   (mode_s)
  );

  assign cpu_is_led   = (cpu_addr == LED_ADDR);
  assign cpu_disp_req = cpu_wr_en & (cpu_is_led | (cpu_addr == SEG_ADDR));
  assign cpu_base_wr  = cpu_wr_en & (cpu_addr == BASE_ADDR);
  assign dbg_force    = cpu_disp_req & dbg_valid & (wait_cnt == WAIT_MAX);

  always_comb begin
    cpu_stall = 1'b0;
    dbg_ready = 1'b0;
    case (state)
      ST_NORMAL: begin
        cpu_stall = dbg_force;
        dbg_ready = dbg_valid & (dbg_force | ~cpu_disp_req);
      end
      ST_DEBUG: dbg_ready = dbg_valid;
      default:  cpu_stall = cpu_disp_req;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_NORMAL;
      wait_cnt   <= '0;
      led_ctrl   <= 1'b0;
      seg_ctrl   <= 1'b0;
      write_data <= '0;
      base       <= 1'b0;
      owner      <= OWNER_CPU;
`ifdef DISP_REPLAY_EN
      shadow_led <= '0;
      shadow_seg <= '0;
      dirty_led  <= 1'b0;
      dirty_seg  <= 1'b0;
`endif
    end else begin
      led_ctrl <= 1'b0;
      seg_ctrl <= 1'b0;
      if (cpu_base_wr) base <= cpu_wdata[0];
      // Counts cycles a pending debug write has been refused; saturates at the forcing threshold.
      if (dbg_valid & ~dbg_ready)
        wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      case (state)
        ST_NORMAL: begin
          if (dbg_ready) begin
            led_ctrl   <= ~dbg_sel;
            seg_ctrl   <= dbg_sel;
            write_data <= dbg_wdata;
          end else if (cpu_disp_req) begin
            led_ctrl   <= cpu_is_led;
            seg_ctrl   <= ~cpu_is_led;
            write_data <= cpu_wdata;
          end
          if (mode_s) begin
            state <= ST_DEBUG;
            owner <= OWNER_DBG;
          end
        end
        ST_DEBUG: begin
          if (dbg_ready) begin
            led_ctrl   <= ~dbg_sel;
            seg_ctrl   <= dbg_sel;
            write_data <= dbg_wdata;
          end
`ifdef DISP_REPLAY_EN
          if (cpu_disp_req) begin
            if (cpu_is_led) begin
              shadow_led <= cpu_wdata;
              dirty_led  <= 1'b1;
            end else begin
              shadow_seg <= cpu_wdata;
              dirty_seg  <= 1'b1;
            end
          end
          if (!mode_s) begin
            state <= ST_REPLAY_LED;
            owner <= OWNER_CPU;
          end
`else
          if (!mode_s) begin
            state <= ST_NORMAL;
            owner <= OWNER_CPU;
          end
`endif
        end
`ifdef DISP_REPLAY_EN
        ST_REPLAY_LED: begin
          if (dirty_led) begin
            led_ctrl   <= 1'b1;
            write_data <= shadow_led;
            dirty_led  <= 1'b0;
          end
          state <= ST_REPLAY_SEG;
        end
        ST_REPLAY_SEG: begin
          if (dirty_seg) begin
            seg_ctrl   <= 1'b1;
            write_data <= shadow_seg;
            dirty_seg  <= 1'b0;
          end
          state <= ST_NORMAL;
        end
`endif
        default: begin
          state <= ST_NORMAL;
          owner <= OWNER_CPU;
        end
      endcase
    end
  end

endmodule
